m1auth_seq: RTL

M1AUTH_SEQ -- requirements
Module: m1auth_seq

---
 rtl/m1auth_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/m1auth_seq.sv
// m1auth_seq: command sequencer for a bit-serial Crypto1 core (key load, 32 shift steps, finish).
// Encrypted-parity generation is compiled in only when M1AUTH_PARITY_EN is defined.
`timescale 1ns/1ps
module m1auth_seq (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [47:0] cmd_key,
    input  logic [31:0] cmd_data,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_out,
    output logic [3:0]  par_out,
    output logic [47:0] m1_key,
    output logic        m1_load_key,
    output logic        m1_start,
    output logic        m1_ser_in,
    output logic        m1_fb,
    input  logic        m1_ks
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [1:0] OP_NESTED = 2'd1;
    localparam logic [1:0] OP_CRYPT  = 2'd3;

    state_t      state_q, state_d;
    logic [4:0]  step_q, step_d;
    logic [47:0] key_q, key_d;
    logic [31:0] dout_q, dout_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] data_q, data_d;
    logic [31:0] work_q, work_d;

    logic [4:0]  bit_idx;
    logic        cur_bit;
    logic        accept;
    logic        fin_commit;

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign accept     = cmd_valid && cmd_ready && !abort;
    assign fin_commit = (state_q == S_FIN) && !abort;
    assign m1_key     = key_q;

    // Step k walks bytes MSB-byte first and bits LSB first inside each byte.
    assign bit_idx = {~step_q[4:3], step_q[2:0]};
    assign cur_bit = data_q[bit_idx];

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        key_d       = key_q;
        dout_d      = dout_q;
        op_d        = op_q;
        data_d      = data_q;
        work_d      = work_q;
        m1_load_key = 1'b0;
        m1_start    = 1'b0;
        m1_ser_in   = 1'b0;
        m1_fb       = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = cmd_op;
                    key_d   = cmd_key;
                    data_d  = cmd_data;
                    step_d  = 5'd0;
                    state_d = cmd_op[1] ? S_SHIFT : S_LOAD;
                end
            end
            S_LOAD: begin
                m1_load_key = 1'b1;
                state_d     = S_SHIFT;
            end
            S_SHIFT: begin
                m1_start        = 1'b1;
                m1_ser_in       = (op_q != OP_CRYPT) && cur_bit;
                m1_fb           = (op_q == OP_NESTED);
                work_d[bit_idx] = cur_bit ^ m1_ks;
                step_d          = step_q + 5'd1;
                if (step_q == 5'd31) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                dout_d  = work_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort drops the command without publishing any partial result.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            done    = 1'b0;
            dout_d  = dout_q;
        end
    end

    // The finishing cycle already presents the new word; it is held from then on.
    assign data_out = fin_commit ? work_q : dout_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= 5'd0;
            key_q   <= 48'd0;
            dout_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            key_q   <= key_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge sysclk) begin
        op_q   <= op_d;
        data_q <= data_d;
        work_q <= work_d;
    end

`ifdef M1AUTH_PARITY_EN
    logic [2:0] parw_q, parw_d;
    logic [3:0] par_q, par_d;
    logic [3:0] par_fin;
    logic [1:0] par_byte;

    function automatic logic byte_odd_par(input logic [31:0] w, input logic [1:0] j);
        logic [7:0] b;
        case (j)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return ~^b;
    endfunction

    assign par_byte = step_q[4:3] - 2'd1;
    assign par_fin  = {byte_odd_par(data_q, 2'd3) ^ m1_ks, parw_q};

    always_comb begin
        parw_d = parw_q;
        // The first step of byte j+1 provides the keystream bit that masks byte j's parity.
        if ((state_q == S_SHIFT) && (step_q[2:0] == 3'd0) && (step_q[4:3] != 2'd0)) begin
            parw_d[par_byte] = byte_odd_par(data_q, par_byte) ^ m1_ks;
        end
        par_d = fin_commit ? par_fin : par_q;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            par_q <= 4'd0;
        end else begin
            par_q <= par_d;
        end
    end

    always_ff @(posedge sysclk) begin
        parw_q <= parw_d;
    end

    assign par_out = fin_commit ? par_fin : par_q;
`else
    assign par_out = 4'd0;
`endif

endmodule
